apb4_arbiter: RTL
=================

APB4_ARBITER -- requirements
Module: apb4_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd256: ACCESS-phase cycles allowed before forced completion (used only when APB4_ARB_TIMEOUT_EN is defined).
REQ-002 Port clk_i  input  1  single clock; all state is updated on its rising edge.
REQ-003 Port rst_i  input  1  reset; asynchronous, active-high.
REQ-004 Port apb_req[2]  apb4_intf slave modport  PADDR 32, PWDATA 32, PWRITE 1, PSEL 1, PENABLE 1 in; PRDATA 32, PREADY 1, PSLVERR 1 out  requester ports; [0] = core, [1] = second master (DMA/debug).
REQ-005 Port apb_out  apb4_intf master modport  same signal set, reversed direction  shared downstream bus, feeds apb4_mux.
REQ-006 Port grant_o  output  2  one-hot owner of apb_out; 2'b00 when idle.
REQ-007 Port busy_o  output  1  high in SETUP or ACCESS.

Function
REQ-008 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-009 IDLE: request = apb_req[i].PSEL; no request -> stay IDLE, apb_out.PSEL=0, PENABLE=0.
REQ-010 Arbitration round-robin: single requester wins; both requesting -> master not granted last wins; last_grant resets to 1 so master 0 wins first contention.
REQ-011 On grant (IDLE->SETUP) the winner's PADDR, PWDATA, PWRITE SHALL be registered and held constant on apb_out until return to IDLE.
REQ-012 Latency: PSEL sampled in cycle N -> apb_out.PSEL=1, PENABLE=0 in N+1 (SETUP); PENABLE=1 in N+2 (ACCESS).
REQ-013 ACCESS: stay while apb_out.PREADY=0; apb_out.PREADY=1 -> granted apb_req.PREADY=1 same cycle (combinational), PRDATA/PSLVERR passed through, next state IDLE.
REQ-014 Non-granted requester: PREADY=0, PSLVERR=0, PRDATA=0 at all times; its request stays pending and SHALL be served no later than after one transfer by the other master.
REQ-015 Back-to-back: one idle cycle between transfers; minimum transfer = 3 cycles including IDLE.
REQ-016 Request dropped by a master after grant (protocol violation) SHALL NOT abort the downstream transfer.
REQ-017 grant_o SHALL be one-hot and stable from SETUP through ACCESS completion; busy_o = (state != IDLE).

Reset
REQ-018 rst_i high SHALL immediately force IDLE, apb_out PSEL/PENABLE/PWRITE=0, PADDR/PWDATA=0, grant_o=0, busy_o=0, last_grant=1, timeout counter=0, independent of clk_i.
REQ-019 Reset during SETUP/ACCESS SHALL abandon the transfer; no PREADY returned to any requester.

Configuration
REQ-020 Macro APB4_ARB_TIMEOUT_EN defined: 16-bit counter clears on SETUP entry, increments each ACCESS cycle with PREADY=0; at count == TIMEOUT_CYCLES-1 the granted requester gets PREADY=1, PSLVERR=1, PRDATA=0, apb_out PSEL/PENABLE drop next cycle, FSM -> IDLE.
REQ-021 Downstream PREADY in the timeout cycle SHALL take priority (normal completion, PSLVERR passed through).
REQ-022 Macro undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Structure
REQ-023 tinyriscv_pkg SHALL hold typedef enum logic [1:0] apb_arb_state_e {IDLE, SETUP, ACCESS} and localparam APB_ARB_NUM_MST = 2.
REQ-024 Sub-module rr_arb2 (inputs req[1:0], last_grant; outputs one-hot gnt) SHALL implement REQ-010; FSM and datapath stay in apb4_arbiter.

Verification
REQ-025 Single master 0 write PADDR=32'h1000_0004, PWDATA=32'hDEAD_BEEF, slave PREADY after 2 wait states -> downstream data matches, apb_req[0].PREADY pulses once at cycle 5, grant_o=2'b01.
REQ-026 Both masters request in same cycle out of reset -> master 0 served first, master 1 next with one IDLE gap, grant_o 01 then 10.
REQ-027 Master 0 requests continuously, master 1 requests once -> grants alternate 0,1,0; master 1 waits at most one transfer.
REQ-028 Read, slave returns PRDATA=32'h1234_5678, PSLVERR=1 -> granted master sees both; other master sees PRDATA=0, PSLVERR=0.
REQ-029 rst_i pulsed mid-ACCESS -> same-cycle apb_out.PSEL=0, grant_o=0, no PREADY upstream; next request served normally.
REQ-030 APB4_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ready -> PREADY=1, PSLVERR=1, PRDATA=0 on 8th ACCESS cycle, FSM back to IDLE.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// Shared types for the two-master APB4 arbiter: FSM state encoding and master count.
package tinyriscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    localparam int APB_ARB_NUM_MST = 2;

endpackage

// File: rtl/apb4_intf.sv
// APB4 signal bundle. The master modport drives the request side; the slave modport answers it.
interface apb4_intf;

    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins; on contention the
// master that did not win last time gets the bus.
module rr_arb2
    import tinyriscv_pkg::*;
(
    input  logic [APB_ARB_NUM_MST-1:0] req,
    input  logic                       last_grant,
    output logic [APB_ARB_NUM_MST-1:0] gnt
);

    // Pick a one-hot winner, alternating when both masters ask at once.
    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/apb4_arbiter.sv
// Two-master APB4 arbiter: round-robin selection, registered downstream address
// phase, combinational response routing back to the owning master.
// Optional build macro APB4_ARB_TIMEOUT_EN adds an ACCESS-phase watchdog that
// completes a stalled transfer with PSLVERR after TIMEOUT_CYCLES cycles.
module apb4_arbiter
    import tinyriscv_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    apb4_intf.slave                    apb_req [APB_ARB_NUM_MST],
    apb4_intf.master                   apb_out,
    output logic [APB_ARB_NUM_MST-1:0] grant_o,
    output logic                       busy_o
);

    apb_arb_state_e state_q, state_d;
    logic [APB_ARB_NUM_MST-1:0] grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;

    logic [APB_ARB_NUM_MST-1:0] req;
    logic [APB_ARB_NUM_MST-1:0] gnt;
    logic        timeout_hit;
    logic        done;
    logic        unused_penable;

    assign req = {apb_req[1].PSEL, apb_req[0].PSEL};

    // Upstream PENABLE carries no information the arbiter needs; PSEL alone is the request.
    assign unused_penable = apb_req[0].PENABLE | apb_req[1].PENABLE;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

`ifdef APB4_ARB_TIMEOUT_EN
    logic [15:0] tcnt_q, tcnt_d;

    assign timeout_hit = (state_q == ACCESS) && !apb_out.PREADY
                         && (tcnt_q == TIMEOUT_CYCLES - 16'd1);

    // Count stalled ACCESS cycles, restarting from zero whenever a new transfer is granted.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == IDLE && |gnt) begin
            tcnt_d = '0;
        end else if (state_q == ACCESS && !apb_out.PREADY && !timeout_hit) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // A downstream PREADY always wins over a watchdog expiry in the same cycle.
    assign done = (state_q == ACCESS) && (apb_out.PREADY || timeout_hit);

    // Next-state and datapath capture: the winner's address phase is latched once at grant.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d      = SETUP;
                    grant_d      = gnt;
                    last_grant_d = gnt[1];
                    if (gnt[1]) begin
                        paddr_d  = apb_req[1].PADDR;
                        pwdata_d = apb_req[1].PWDATA;
                        pwrite_d = apb_req[1].PWRITE;
                    end else begin
                        paddr_d  = apb_req[0].PADDR;
                        pwdata_d = apb_req[0].PWDATA;
                        pwrite_d = apb_req[0].PWRITE;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    // FSM, ownership and downstream address-phase registers; reset abandons any transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
        end
    end

    assign apb_out.PSEL    = psel_q;
    assign apb_out.PENABLE = penable_q;
    assign apb_out.PADDR   = paddr_q;
    assign apb_out.PWDATA  = pwdata_q;
    assign apb_out.PWRITE  = pwrite_q;

    assign grant_o = grant_q;
    assign busy_o  = psel_q;

    // Only the owner ever sees a response; a watchdog expiry reports an error with no data.
    for (genvar i = 0; i < APB_ARB_NUM_MST; i++) begin : g_resp
        assign apb_req[i].PREADY  = done && grant_q[i];
        assign apb_req[i].PRDATA  = (done && grant_q[i] && !timeout_hit) ? apb_out.PRDATA : 32'h0;
        assign apb_req[i].PSLVERR = done && grant_q[i] && (timeout_hit || apb_out.PSLVERR);
    end

endmodule
